// File: rtl/fb_vga_pkg.sv
// fb_vga_pkg: VGA 640x480@60 timing constants, framebuffer geometry and the
// pixel/flag types shared by the framebuffer scan-out block.
package fb_vga_pkg;

    typedef logic [9:0] cnt_t;

    // Horizontal timing, in pixel clocks.
    localparam cnt_t H_VISIBLE    = 10'd640;
    localparam cnt_t H_FRONT      = 10'd16;
    localparam cnt_t H_SYNC       = 10'd96;
    localparam cnt_t H_TOTAL      = 10'd800;
    localparam cnt_t H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam cnt_t H_LAST       = H_TOTAL - 10'd1;

    // Vertical timing, in lines.
    localparam cnt_t V_VISIBLE    = 10'd480;
    localparam cnt_t V_FRONT      = 10'd10;
    localparam cnt_t V_SYNC       = 10'd2;
    localparam cnt_t V_TOTAL      = 10'd525;
    localparam cnt_t V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam cnt_t V_LAST       = V_TOTAL - 10'd1;

    // 64x64 framebuffer shown as a 256x256 window (4x4 pixel replication).
    localparam int FB_AW    = 12;
    localparam int FB_DEPTH = 1 << FB_AW;
    localparam int WIN_SIZE = 256;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam rgb444_t RGB_BLACK = '0;

    // Per-pixel attributes that travel alongside the RAM read.
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic active;
        logic window;
        logic tick;
    } pix_flags_t;

    localparam pix_flags_t FLAGS_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, active: 1'b0,
                                          window: 1'b0, tick: 1'b0};

    // Half intensity: each channel shifted right by one (F -> 7).
    function automatic rgb444_t rgb_half(input rgb444_t c);
        rgb444_t h;
        h.r = c.r >> 1;
        h.g = c.g >> 1;
        h.b = c.b >> 1;
        return h;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// fb_ram: 4096x12 simple dual-port framebuffer RAM, one synchronous write
// port and one registered read port, read-before-write on address collision.
module fb_ram
    import fb_vga_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [FB_AW-1:0] wr_addr_i,
    input  rgb444_t          wr_data_i,
    input  logic [FB_AW-1:0] rd_addr_i,
    output rgb444_t          rd_data_o
);

    rgb444_t mem_q [FB_DEPTH];
    rgb444_t rd_data_q;

    // Write and read on the same edge; the read returns the pre-write contents.
    // NOTE: non-blocking assignments make the read sample the array before this
    // edge's write lands, which is exactly the read-before-write behaviour.
    // NOTE: the storage array has no reset so it maps onto block RAM; image
    // contents deliberately survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fb_vga_scanout.sv
// fb_vga_scanout: 640x480@60 VGA scan-out of a 64x64 RGB444 framebuffer,
// displayed 4x magnified in a 256x256 window. Counter-to-pin latency is two
// clocks (RAM read, output register) for colour, syncs and frame_tick alike.
// Optional build macro FB_SCANLINE_EN halves the intensity of odd lines
// inside the window; without it every line is shown at full intensity.
module fb_vga_scanout
    import fb_vga_pkg::*;
#(
    parameter int H_OFFSET = 192,
    parameter int V_OFFSET = 112
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        write_en,
    input  logic [5:0]  write_x,
    input  logic [5:0]  write_y,
    input  logic [11:0] pixel_color,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_tick
);

    localparam cnt_t WIN_H_LO = cnt_t'(H_OFFSET);
    localparam cnt_t WIN_H_HI = cnt_t'(H_OFFSET + WIN_SIZE);
    localparam cnt_t WIN_V_LO = cnt_t'(V_OFFSET);
    localparam cnt_t WIN_V_HI = cnt_t'(V_OFFSET + WIN_SIZE);

    cnt_t             h_cnt_q, h_cnt_d;
    cnt_t             v_cnt_q, v_cnt_d;
    pix_flags_t       flags_d, flags_q;
    logic [FB_AW-1:0] rd_addr;
    logic             fb_wr_en;
    rgb444_t          rd_data;
    rgb444_t          pix_color_d;
    rgb444_t          rgb_q;
    logic             hs_q, vs_q, tick_q;
`ifdef FB_SCANLINE_EN
    logic             odd_line_q;
`endif

    // Raster counter next state: h wraps at end of line, v steps on each h wrap.
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    // Raster counter registers, restarting at the top-left on reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Decode sync/active/window for the current position and form the RAM
    // read address; dropping the two LSBs of each offset gives 4x4 replication.
    always_comb begin
        flags_d.hs_n   = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
        flags_d.vs_n   = !((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
        flags_d.active = (h_cnt_q < H_VISIBLE) && (v_cnt_q < V_VISIBLE);
        flags_d.window = (h_cnt_q >= WIN_H_LO) && (h_cnt_q < WIN_H_HI) &&
                         (v_cnt_q >= WIN_V_LO) && (v_cnt_q < WIN_V_HI);
        flags_d.tick   = (h_cnt_q == '0) && (v_cnt_q == V_VISIBLE);
        rd_addr        = {6'((v_cnt_q - WIN_V_LO) >> 2), 6'((h_cnt_q - WIN_H_LO) >> 2)};
    end

    // Writes are dropped while reset is asserted; the stored image is untouched.
    assign fb_wr_en = write_en & resetn;

    fb_ram u_fb_ram (
        .clk       (clk),
        .wr_en_i   (fb_wr_en),
        .wr_addr_i ({write_y, write_x}),
        .wr_data_i (rgb444_t'(pixel_color)),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // Stage 1: register the pixel flags in step with the RAM read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            flags_q    <= FLAGS_IDLE;
`ifdef FB_SCANLINE_EN
            odd_line_q <= 1'b0;
`endif
        end else begin
            flags_q    <= flags_d;
`ifdef FB_SCANLINE_EN
            odd_line_q <= v_cnt_q[0];
`endif
        end
    end

    // Colour select: stored colour inside the window, black everywhere else.
    always_comb begin
        pix_color_d = RGB_BLACK;
        if (flags_q.active && flags_q.window) begin
`ifdef FB_SCANLINE_EN
            pix_color_d = odd_line_q ? rgb_half(rd_data) : rd_data;
`else
            pix_color_d = rd_data;
`endif
        end
    end

    // Stage 2: output register for colour, syncs and the frame tick.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            tick_q <= 1'b0;
            rgb_q  <= RGB_BLACK;
        end else begin
            hs_q   <= flags_q.hs_n;
            vs_q   <= flags_q.vs_n;
            tick_q <= flags_q.tick;
            rgb_q  <= pix_color_d;
        end
    end

    assign vga_hs     = hs_q;
    assign vga_vs     = vs_q;
    assign frame_tick = tick_q;
    assign vga_r      = rgb_q.r;
    assign vga_g      = rgb_q.g;
    assign vga_b      = rgb_q.b;

endmodule

// File: tb/tb_fb_vga_scanout.sv
// tb_fb_vga_scanout: directed bench for fb_vga_scanout with a cycle-accurate
// scoreboard. Expected output for each counter position is queued when that
// position is presented and popped two clocks later. To keep runs short the
// raster counters are jumped forward by depositing new values.
module tb_fb_vga_scanout;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        write_en = 1'b0;
    logic [5:0]  write_x = '0;
    logic [5:0]  write_y = '0;
    logic [11:0] pixel_color = '0;
    logic        vga_hs, vga_vs, frame_tick;
    logic [3:0]  vga_r, vga_g, vga_b;

    fb_vga_scanout #(.H_OFFSET(192), .V_OFFSET(112)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .write_en    (write_en),
        .write_x     (write_x),
        .write_y     (write_y),
        .pixel_color (pixel_color),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] val;
        int          h;
        int          v;
    } sb_t;

    localparam logic [14:0] BLANK = {1'b1, 1'b1, 1'b0, 12'h000};
    localparam int RUN_LIMIT = 20000;
`ifdef FB_SCANLINE_EN
    localparam logic [11:0] ODD_FULL = 12'h777;
`else
    localparam logic [11:0] ODD_FULL = 12'hFFF;
`endif

    sb_t         sb_q[$];
    logic [11:0] fb_m [4096];
    int          m_h, m_v;
    bit          armed;
    int          total, bad;
    int          hs_low, vs_low, ticks;
    logic [9:0]  jump_h, jump_v;

    // Reference model of the pins for counter position (h, v).
    function automatic logic [14:0] exp_out(input int h, input int v);
        logic        hs, vs, tk;
        logic [11:0] c;
        int          a;
        hs = !(h >= 656 && h <= 751);
        vs = !(v == 490 || v == 491);
        tk = (h == 0 && v == 480);
        c  = 12'h000;
        if (h < 640 && v < 480 && h >= 192 && h < 448 && v >= 112 && v < 368) begin
            a = ((v - 112) / 4) * 64 + (h - 192) / 4;
            c = fb_m[a];
`ifdef FB_SCANLINE_EN
            if (v % 2 == 1) c = {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
`endif
        end
        return {hs, vs, tk, c};
    endfunction

    function automatic logic [14:0] dut_out();
        return {vga_hs, vga_vs, frame_tick, vga_r, vga_g, vga_b};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, got, want);
            $error("check %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic fail_now(input string tag);
        total++;
        bad++;
        $display("FAIL %s: observed=not reached expected=reached", tag);
    endtask

    // One clock: compare the due entry, queue this position, advance the model.
    task automatic tick();
        sb_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("scan h=%0d v=%0d", e.h, e.v), dut_out(), e.val);
        end
        if (armed) begin
            if (vga_hs === 1'b0) hs_low++;
            if (vga_vs === 1'b0) vs_low++;
            if (frame_tick === 1'b1) ticks++;
            e.val = exp_out(m_h, m_v);
            e.h   = m_h;
            e.v   = m_v;
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (!resetn) begin
            m_h = 0;
            m_v = 0;
            sb_q.delete();
            e.val = BLANK; e.h = -1; e.v = -1;
            sb_q.push_back(e);
            sb_q.push_back(e);
            armed = 1'b1;
        end else begin
            if (write_en) fb_m[{write_y, write_x}] = pixel_color;
            if (m_h == 799) begin
                m_h = 0;
                m_v = (m_v == 524) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(m_h == h && m_v == v) && n < RUN_LIMIT) begin
            tick();
            n++;
        end
        if (!(m_h == h && m_v == v)) fail_now($sformatf("timeout h=%0d v=%0d", h, v));
    endtask

    // Deposit a new raster position into the DUT counters and the model.
    task automatic jump(input int h, input int v);
        jump_h = 10'(h);
        jump_v = 10'(v);
        force dut.h_cnt_q = jump_h;
        force dut.v_cnt_q = jump_v;
        #1;
        release dut.h_cnt_q;
        release dut.v_cnt_q;
        m_h = h;
        m_v = v;
    endtask

    task automatic probe(input int h, input int v, input logic [11:0] want, input string tag);
        jump(h, v);
        tick();
        tick();
        check(tag, {vga_r, vga_g, vga_b}, want);
    endtask

    task automatic clear_stats();
        hs_low = 0;
        vs_low = 0;
        ticks  = 0;
    endtask

    task automatic fill(input logic [11:0] base, input logic [11:0] c00, input logic [11:0] c63);
        write_en = 1'b1;
        for (int y = 0; y < 64; y++) begin
            for (int x = 0; x < 64; x++) begin
                write_x = 6'(x);
                write_y = 6'(y);
                pixel_color = (x == 0 && y == 0) ? c00 : (x == 63 && y == 63) ? c63 : base;
                tick();
            end
        end
        write_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=time limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        total = 0; bad = 0; armed = 1'b0;
        clear_stats();
        @(negedge clk);

        // Reset state.
        resetn = 1'b0;
        run_n(3);
        check("rst_hs", vga_hs, 1'b1);
        check("rst_vs", vga_vs, 1'b1);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("rst_tick", frame_tick, 1'b0);
        resetn = 1'b1;

        // Clear image, red at (0,0), blue at (63,63).
        fill(12'h000, 12'hF00, 12'h00F);

        // One line of horizontal timing.
        run_to(0, 7);
        clear_stats();
        run_n(800);
        check("hs_low_per_line", hs_low, 96);
        check("vs_low_visible_line", vs_low, 0);

        // Mapping and two-clock latency.
        jump(180, 112);
        run_to(192, 112);
        tick();
        check("lag1_h191", {vga_r, vga_g, vga_b}, 12'h000);
        tick();
        check("lag2_red_h192", {vga_r, vga_g, vga_b}, 12'hF00);
        probe(195, 115, 12'hF00, "red_h195_v115");
        probe(196, 112, 12'h000, "black_h196");
        probe(192, 116, 12'h000, "black_v116");
        probe(444, 364, 12'h00F, "blue_h444_v364");
        probe(447, 367, 12'h00F, "blue_h447_v367");
        probe(443, 367, 12'h000, "black_h443");
        jump(0, 110);
        run_to(0, 118);

        // Read/write collision at (10,10): h=232, v=152.
        jump(226, 152);
        run_to(232, 152);
        write_x = 6'd10; write_y = 6'd10; pixel_color = 12'h0F0; write_en = 1'b1;
        tick();
        write_en = 1'b0;
        tick();
        check("coll_old_data", {vga_r, vga_g, vga_b}, 12'h000);
        tick();
        check("coll_next_read", {vga_r, vga_g, vga_b}, 12'h0F0);
        jump(795, 524);
        run_to(0, 0);
        probe(232, 152, 12'h0F0, "coll_next_frame");

        // Frame tick at the start of vertical blanking.
        jump(790, 479);
        run_to(0, 480);
        tick();
        check("ftick_before", frame_tick, 1'b0);
        tick();
        check("ftick_pulse", frame_tick, 1'b1);
        tick();
        check("ftick_after", frame_tick, 1'b0);

        // Fill white during blanking, then count syncs over ten lines.
        fill(12'hFFF, 12'hFFF, 12'hFFF);
        run_to(0, 486);
        clear_stats();
        run_n(8000);
        check("vs_low_cycles", vs_low, 1600);
        check("hs_low_10_lines", hs_low, 960);
        check("ftick_none_in_blank", ticks, 0);

        // Window edges.
        probe(191, 112, 12'h000, "edge_h191");
        probe(192, 200, 12'hFFF, "in_h192");
        probe(447, 200, 12'hFFF, "in_h447");
        probe(448, 200, 12'h000, "edge_h448");
        probe(300, 111, 12'h000, "edge_v111");
        probe(300, 112, 12'hFFF, "in_v112");
        probe(300, 367, ODD_FULL, "in_v367");
        probe(300, 368, 12'h000, "edge_v368");

        // Scanline option: even line full, odd line halved only when enabled.
        probe(192, 112, 12'hFFF, "line_v112");
        probe(192, 113, ODD_FULL, "line_v113");

        // Mid-frame reset with a write attempted during reset.
        jump(300, 200);
        resetn = 1'b0;
        write_x = 6'd5; write_y = 6'd5; pixel_color = 12'h0F0; write_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("midrst_out_%0d", i), dut_out(), BLANK);
        end
        resetn = 1'b1;
        write_en = 1'b0;
        n = 0;
        while (vga_hs !== 1'b0 && n < 1000) begin
            tick();
            n++;
        end
        check("restart_first_hs", n, 658);
        probe(212, 132, 12'hFFF, "rst_write_ignored");
        probe(192, 112, 12'hFFF, "kept_after_reset");
        probe(444, 364, 12'hFFF, "kept_after_reset_br");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_vga_scanout.md
FB_VGA_SCANOUT -- requirements
Module: fb_vga_scanout

Interface
REQ-001 SHALL have parameter H_OFFSET, default 192: first visible column of the 256x256 image window.
REQ-002 SHALL have parameter V_OFFSET, default 112: first visible line of the image window.
REQ-003 SHALL have port clk, input, 1: single clock, 25 MHz pixel clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port write_en, input, 1: framebuffer write strobe.
REQ-006 SHALL have port write_x, input, 6: write column 0..63.
REQ-007 SHALL have port write_y, input, 6: write row 0..63.
REQ-008 SHALL have port pixel_color, input, 12: write data, RGB444 {R[11:8],G[7:4],B[3:0]}.
REQ-009 SHALL have ports vga_hs and vga_vs, output, 1 each: sync signals, active-low.
REQ-010 SHALL have ports vga_r, vga_g and vga_b, output, 4 each: colour outputs.
REQ-011 SHALL have port frame_tick, output, 1: one-cycle pulse at start of vertical blanking.

Function
REQ-012 SHALL store a 64x64x12 framebuffer; address = {write_y, write_x}; written on every clk edge with write_en=1.
REQ-013 SHALL run h_cnt 0..799, wrapping to 0; v_cnt 0..524, increments when h_cnt wraps, wraps to 0 after 524.
REQ-014 SHALL assert hs low for h_cnt 656..751 and vs low for v_cnt 490..491; active video is h_cnt<640 and v_cnt<480.
REQ-015 SHALL treat a pixel as in-window when H_OFFSET<=h_cnt<H_OFFSET+256 and V_OFFSET<=v_cnt<V_OFFSET+256.
REQ-016 SHALL read framebuffer address {(v_cnt-V_OFFSET)[7:2], (h_cnt-H_OFFSET)[7:2]}, giving 4x4 replication of each stored pixel.
REQ-017 SHALL drive RGB = stored colour in-window, 12'h000 when active but out of window, 12'h000 during blanking.
REQ-018 SHALL use a fixed 2-cycle latency from counter value to outputs: cycle 1 is the RAM read, cycle 2 is the output register.
REQ-019 SHALL delay hs, vs and active/window flags by the same 2 cycles, so sync and colour stay aligned.
REQ-020 SHALL handle a same-cycle write and read of one address read-before-write: the old data is displayed and the new data appears from the next frame.
REQ-021 SHALL pulse frame_tick for exactly one cycle, 2 cycles after the counters reach h_cnt=0, v_cnt=480.
REQ-022 SHALL accept writes at any time, including blanking and active video, with no backpressure.

Reset
REQ-023 SHALL, while resetn=0 at a clk edge, clear h_cnt, v_cnt and pipeline flags; outputs SHALL be vga_hs=1, vga_vs=1, RGB=0, frame_tick=0.
REQ-024 SHALL NOT clear framebuffer contents on reset; writes with resetn=0 SHALL be ignored.
REQ-025 SHALL, after a mid-frame reset, restart at h_cnt=0, v_cnt=0 on the first cycle with resetn=1; the first valid pixel appears 2 cycles later.

Configuration
REQ-026 SHALL support macro FB_SCANLINE_EN; when defined, colour on odd v_cnt lines in-window SHALL be each channel shifted right by 1 (e.g. F->7).
REQ-027 SHALL, when FB_SCANLINE_EN is undefined, output all lines at full intensity, with identical timing and ports.

Structure
REQ-028 SHALL place VGA timing constants (H_VISIBLE 640, H_FRONT 16, H_SYNC 96, H_TOTAL 800, V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_TOTAL 525) and the rgb444_t typedef in package fb_vga_pkg.
REQ-029 SHALL instantiate sub-module fb_ram: simple dual-port, 4096x12, one sync write port, one sync read port, read-before-write.

Verification
REQ-030 SHALL verify timing: after reset, hs low exactly 96 cycles per 800, vs low exactly 2 lines per 525, frame_tick once per 420000 cycles.
REQ-031 SHALL verify mapping: write (x=0,y=0)=12'hF00 and (x=63,y=63)=12'h00F -> red at output h=192..195, v=112..115; blue at h=444..447, v=364..367; output lags counters by 2 cycles.
REQ-032 SHALL verify window edges: write all 4096 pixels as 12'hFFF -> RGB=0 at h=191 and h=448, at v=111 and v=368, and 12'hFFF inside.
REQ-033 SHALL verify collision: during frame N write (10,10)=12'h0F0 on the same cycle its address is read, old value 12'h000 -> frame N shows 000 at that read, frame N+1 shows 0F0.
REQ-034 SHALL verify mid-frame reset: assert resetn=0 for 3 cycles at v=200 -> hs=vs=1 and RGB=0 during reset; counters restart at 0 and stored pixels are still present afterwards.
REQ-035 SHALL verify FB_SCANLINE_EN: with pixel 12'hFFF at (0,0), line v=113 outputs 12'h777 and line v=112 outputs 12'hFFF; with the macro undefined, both lines output 12'hFFF.
